alu_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences the ALU operation select, control-store opcode and up/down bit for every instruction the core executes.
- Latches a decoded instruction on start and walks it through its execute, address, memory and writeback cycles.
- Drives the ALU operation mux selects, register-file write enable and memory request each cycle.
- Sits between the instruction decoder and the datapath; it is the only block that drives the ALU operation mux select.

---
 rtl/alu_op_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Multi-cycle instruction sequencer: walks each decoded instruction through its
// execute / address / memory / writeback cycles and drives the ALU op selects.
module alu_op_sequencer #(
   parameter logic [3:0] CS_MOV  = 4'hD,
   parameter int         CLASS_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [CLASS_W-1:0] instr_class,
   input  logic [3:0]         ir_op,
   input  logic               u_bit,
   input  logic               w_bit,
   input  logic [15:0]        reg_list,
   input  logic               mem_ready,
   output logic               busy,
   output logic [1:0]         alu_op_mux,
   output logic [3:0]         cs_op,
   output logic               u,
   output logic [3:0]         reg_sel,
   output logic               mem_req,
   output logic               rf_we,
   output logic               done
);

   localparam logic [CLASS_W-1:0] CLASS_DP    = CLASS_W'(0);
   localparam logic [CLASS_W-1:0] CLASS_LS    = CLASS_W'(1);
   localparam logic [CLASS_W-1:0] CLASS_BLOCK = CLASS_W'(2);

   localparam logic [1:0] MUX_IR     = 2'b00;
   localparam logic [1:0] MUX_CS     = 2'b01;
   localparam logic [1:0] MUX_ADDSUB = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_ADDR,
      S_MEM,
      S_WB,
      S_XFER,
      S_NULL
   } state_t;

   state_t      state_q, state_d;
   logic        u_bit_q, u_bit_d;
   logic        w_bit_q, w_bit_d;
   logic [15:0] list_q, list_d;

   logic        busy_q, busy_d;
   logic [1:0]  alu_op_mux_q, alu_op_mux_d;
   logic [3:0]  cs_op_q, cs_op_d;
   logic        u_q, u_d;
   logic [3:0]  reg_sel_q, reg_sel_d;
   logic        mem_req_q, mem_req_d;
   logic        rf_we_q, rf_we_d;
   logic        done_c;

   logic [3:0]  cur_idx;
   logic [15:0] cur_bit;
   logic [15:0] list_after;

   // The opcode field is routed straight to the datapath, never through here.
   logic unused_ir_op;
   assign unused_ir_op = ^ir_op;

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

   assign cur_idx    = lowest_set(list_q);
   assign cur_bit    = 16'd1 << cur_idx;
   assign list_after = list_q & ~cur_bit;

   always_comb begin
      state_d = state_q;
      u_bit_d = u_bit_q;
      w_bit_d = w_bit_q;
      list_d  = list_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               u_bit_d = u_bit;
               w_bit_d = w_bit;
               list_d  = reg_list;
               if (instr_class == CLASS_DP)
                  state_d = S_EXEC;
               else if (instr_class == CLASS_LS)
                  state_d = S_ADDR;
               else if (instr_class == CLASS_BLOCK && reg_list != 16'd0)
                  state_d = S_XFER;
               else
                  state_d = S_NULL;
            end
         end
         S_EXEC: state_d = S_IDLE;
         S_ADDR: state_d = S_MEM;
         S_MEM: begin
            if (mem_ready) state_d = w_bit_q ? S_WB : S_IDLE;
         end
         S_WB:   state_d = S_IDLE;
         S_XFER: begin
            if (mem_ready) begin
               list_d = list_after;
               if (list_after == 16'd0) state_d = w_bit_q ? S_WB : S_IDLE;
            end
         end
         S_NULL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs are precomputed from the next state so they are registered.
   always_comb begin
      busy_d       = (state_d != S_IDLE);
      alu_op_mux_d = MUX_IR;
      cs_op_d      = 4'd0;
      u_d          = 1'b0;
      reg_sel_d    = 4'd0;
      mem_req_d    = 1'b0;
      rf_we_d      = 1'b0;
      case (state_d)
         S_EXEC: rf_we_d = 1'b1;
         S_ADDR: begin
            alu_op_mux_d = MUX_ADDSUB;
            u_d          = u_bit_d;
         end
         S_MEM: begin
            alu_op_mux_d = MUX_CS;
            cs_op_d      = CS_MOV;
            mem_req_d    = 1'b1;
         end
         S_WB: begin
            alu_op_mux_d = MUX_ADDSUB;
            u_d          = u_bit_d;
            rf_we_d      = 1'b1;
         end
         S_XFER: begin
            alu_op_mux_d = MUX_ADDSUB;
            u_d          = u_bit_d;
            reg_sel_d    = lowest_set(list_d);
            mem_req_d    = 1'b1;
         end
         default: ;
      endcase
   end

   // done fires on the final cycle, which for memory states is the mem_ready cycle.
   always_comb begin
      done_c = 1'b0;
      case (state_q)
         S_EXEC, S_WB, S_NULL: done_c = 1'b1;
         S_MEM:  done_c = mem_ready && !w_bit_q;
         S_XFER: done_c = mem_ready && !w_bit_q && (list_after == 16'd0);
         default: done_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         u_bit_q      <= 1'b0;
         w_bit_q      <= 1'b0;
         list_q       <= 16'd0;
         busy_q       <= 1'b0;
         alu_op_mux_q <= 2'b00;
         cs_op_q      <= 4'd0;
         u_q          <= 1'b0;
         reg_sel_q    <= 4'd0;
         mem_req_q    <= 1'b0;
         rf_we_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         u_bit_q      <= u_bit_d;
         w_bit_q      <= w_bit_d;
         list_q       <= list_d;
         busy_q       <= busy_d;
         alu_op_mux_q <= alu_op_mux_d;
         cs_op_q      <= cs_op_d;
         u_q          <= u_d;
         reg_sel_q    <= reg_sel_d;
         mem_req_q    <= mem_req_d;
         rf_we_q      <= rf_we_d;
      end
   end

   assign busy       = busy_q;
   assign alu_op_mux = alu_op_mux_q;
   assign cs_op      = cs_op_q;
   assign u          = u_q;
   assign reg_sel    = reg_sel_q;
   assign mem_req    = mem_req_q;
   assign rf_we      = rf_we_q;
   assign done       = done_c;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: hand-computed expectations, one line per step.
module tb_alu_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  instr_class;
   logic [3:0]  ir_op;
   logic        u_bit;
   logic        w_bit;
   logic [15:0] reg_list;
   logic        mem_ready;
   logic        busy;
   logic [1:0]  alu_op_mux;
   logic [3:0]  cs_op;
   logic        u;
   logic [3:0]  reg_sel;
   logic        mem_req;
   logic        rf_we;
   logic        done;

   int n_total;
   int n_pass;

   alu_op_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .instr_class (instr_class),
      .ir_op       (ir_op),
      .u_bit       (u_bit),
      .w_bit       (w_bit),
      .reg_list    (reg_list),
      .mem_ready   (mem_ready),
      .busy        (busy),
      .alu_op_mux  (alu_op_mux),
      .cs_op       (cs_op),
      .u           (u),
      .reg_sel     (reg_sel),
      .mem_req     (mem_req),
      .rf_we       (rf_we),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Snapshot check of every output against one expected vector.
   task automatic chk_all(input string tag, input logic b, input logic [1:0] mx,
                          input logic [3:0] cs, input logic uu, input logic [3:0] rs,
                          input logic mr, input logic we, input logic dn);
      $display("step %s: busy=%0b mux=%0d cs=%0h u=%0b reg_sel=%0d mem_req=%0b rf_we=%0b done=%0b",
               tag, busy, alu_op_mux, cs_op, u, reg_sel, mem_req, rf_we, done);
      chk({tag, ".busy"},    {15'd0, busy},    {15'd0, b});
      chk({tag, ".mux"},     {14'd0, alu_op_mux}, {14'd0, mx});
      chk({tag, ".cs_op"},   {12'd0, cs_op},   {12'd0, cs});
      chk({tag, ".u"},       {15'd0, u},       {15'd0, uu});
      chk({tag, ".reg_sel"}, {12'd0, reg_sel}, {12'd0, rs});
      chk({tag, ".mem_req"}, {15'd0, mem_req}, {15'd0, mr});
      chk({tag, ".rf_we"},   {15'd0, rf_we},   {15'd0, we});
      chk({tag, ".done"},    {15'd0, done},    {15'd0, dn});
   endtask

   // Advance one cycle, then present this cycle's mem_ready and let done settle.
   task automatic tick(input logic mr);
      @(posedge clk);
      #1;
      mem_ready = mr;
      #1;
   endtask

   initial begin
      n_total     = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      instr_class = 2'b00;
      ir_op       = 4'h7;
      u_bit       = 1'b0;
      w_bit       = 1'b0;
      reg_list    = 16'd0;
      mem_ready   = 1'b0;

      #22;
      chk_all("reset", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);
      rst_n = 1'b1;
      tick(0);
      chk_all("idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Data processing
      start = 1; instr_class = 2'b00; u_bit = 1;
      tick(0);
      start = 0;
      chk_all("dp.exec", 1, 2'b00, 4'h0, 0, 4'd0, 0, 1, 1);
      tick(0);
      chk_all("dp.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Load, u=0, w=1, two wait cycles
      start = 1; instr_class = 2'b01; u_bit = 0; w_bit = 1;
      tick(0);
      start = 0;
      chk_all("ld.addr", 1, 2'b10, 4'h0, 0, 4'd0, 0, 0, 0);
      tick(0);
      chk_all("ld.mem0", 1, 2'b01, 4'hD, 0, 4'd0, 1, 0, 0);
      tick(0);
      chk_all("ld.mem1", 1, 2'b01, 4'hD, 0, 4'd0, 1, 0, 0);
      tick(1);
      chk_all("ld.mem2", 1, 2'b01, 4'hD, 0, 4'd0, 1, 0, 0);
      tick(0);
      chk_all("ld.wb", 1, 2'b10, 4'h0, 0, 4'd0, 0, 1, 1);
      tick(0);
      chk_all("ld.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Block transfer 8011, u=1, w=0, mem_ready always high
      start = 1; instr_class = 2'b10; u_bit = 1; w_bit = 0; reg_list = 16'h8011;
      tick(1);
      start = 0;
      chk_all("blk.x0", 1, 2'b10, 4'h0, 1, 4'd0, 1, 0, 0);
      tick(1);
      chk_all("blk.x4", 1, 2'b10, 4'h0, 1, 4'd4, 1, 0, 0);
      tick(1);
      chk_all("blk.x15", 1, 2'b10, 4'h0, 1, 4'd15, 1, 0, 1);
      tick(1);
      chk_all("blk.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Empty block list with writeback requested
      start = 1; instr_class = 2'b10; w_bit = 1; reg_list = 16'h0000;
      tick(0);
      start = 0;
      chk_all("blk0.null", 1, 2'b00, 4'h0, 0, 4'd0, 0, 0, 1);
      tick(0);
      chk_all("blk0.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Reserved class
      start = 1; instr_class = 2'b11; reg_list = 16'hFFFF;
      tick(0);
      start = 0;
      chk_all("rsv.null", 1, 2'b00, 4'h0, 0, 4'd0, 0, 0, 1);
      tick(0);
      chk_all("rsv.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // start held through a store with w=0: one IDLE gap then re-accepted
      start = 1; instr_class = 2'b01; u_bit = 1; w_bit = 0;
      tick(0);
      chk_all("hold.addr", 1, 2'b10, 4'h0, 1, 4'd0, 0, 0, 0);
      tick(1);
      chk_all("hold.mem", 1, 2'b01, 4'hD, 0, 4'd0, 1, 0, 1);
      tick(0);
      chk_all("hold.gap", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);
      tick(0);
      start = 0;
      chk_all("hold.addr2", 1, 2'b10, 4'h0, 1, 4'd0, 0, 0, 0);
      tick(1);
      chk_all("hold.mem2", 1, 2'b01, 4'hD, 0, 4'd0, 1, 0, 1);
      tick(0);
      chk_all("hold.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      // Reset in the middle of a stalled block transfer
      start = 1; instr_class = 2'b10; u_bit = 0; w_bit = 1; reg_list = 16'h0006;
      tick(0);
      start = 0;
      chk_all("rst.x1", 1, 2'b10, 4'h0, 0, 4'd1, 1, 0, 0);
      tick(0);
      chk_all("rst.x1wait", 1, 2'b10, 4'h0, 0, 4'd1, 1, 0, 0);
      rst_n = 1'b0;
      #1;
      chk_all("rst.abort", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);
      tick(0);
      chk_all("rst.held", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);
      rst_n = 1'b1;
      start = 1; instr_class = 2'b00;
      tick(0);
      start = 0;
      chk_all("rst.dp", 1, 2'b00, 4'h0, 0, 4'd0, 0, 1, 1);
      tick(0);
      chk_all("rst.idle", 0, 2'b00, 4'h0, 0, 4'd0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
